// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared hazard-control types and pipeline stage indices
package mips_core_pkg;

    typedef enum logic {
        HZ_IDLE,
        HZ_REDIRECT_PEND
    } HazardState;

    typedef enum logic [2:0] {
        HC_NONE,
        HC_DC,
        HC_MISPREDICT,
        HC_LW,
        HC_IC
    } HazardCause;

    localparam int NUM_STAGES = 5;
    localparam int STG_IF     = 0;
    localparam int STG_DEC    = 1;
    localparam int STG_EX     = 2;
    localparam int STG_MEM    = 3;
    localparam int STG_WB     = 4;

endpackage

// File: rtl/hazard_watchdog.sv
// rtl/hazard_watchdog.sv - consecutive-stall counter with sticky timeout flag
module hazard_watchdog #(
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_stall_any,
    output logic o_timeout
);

    localparam int W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(STALL_TIMEOUT);

    logic [W-1:0] r_cnt;
    logic         r_timeout;

    // Flag sets on the edge where the count reaches LIMIT; count then saturates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!i_stall_any) begin
                r_cnt <= '0;
            end else if (r_cnt != LIMIT) begin
                r_cnt <= r_cnt + W'(1);
            end
            if (i_stall_any && (r_cnt >= LIMIT - W'(1))) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - per-stage stall/flush generation for the 5-stage pipeline
// Optional perf counters enabled by HAZARD_PERF_COUNTERS_EN.
module hazard_controller
    import mips_core_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1024
`ifdef HAZARD_PERF_COUNTERS_EN
    , parameter int CNT_WIDTH   = 32
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_lw_hazard,
    input  logic i_ic_miss,
    input  logic i_dc_miss,
    input  logic i_ex_mispredict,
    output logic o_if_stall,
    output logic o_dec_stall,
    output logic o_ex_stall,
    output logic o_mem_stall,
    output logic o_wb_stall,
    output logic o_if_flush,
    output logic o_dec_flush,
    output logic o_ex_flush,
    output logic o_mem_flush,
    output logic o_wb_flush,
    output logic o_stall_timeout
`ifdef HAZARD_PERF_COUNTERS_EN
    , output logic [CNT_WIDTH-1:0] o_cnt_lw
    , output logic [CNT_WIDTH-1:0] o_cnt_ic
    , output logic [CNT_WIDTH-1:0] o_cnt_dc
    , output logic [CNT_WIDTH-1:0] o_cnt_mispredict
`endif
);

    HazardState              r_state;
    HazardCause              w_cause;
    logic [NUM_STAGES-1:0]   w_stall_raw;
    logic [NUM_STAGES-1:0]   w_flush;
    logic [NUM_STAGES-1:0]   w_stall;
    logic                    w_redirect_drop;

    always_comb begin
        w_cause = HC_NONE;
        if (i_dc_miss) begin
            w_cause = HC_DC;
        end else if (i_ex_mispredict) begin
            w_cause = HC_MISPREDICT;
        end else if (i_lw_hazard) begin
            w_cause = HC_LW;
        end else if (i_ic_miss) begin
            w_cause = HC_IC;
        end
    end

    // Wrong-path word from the outstanding miss is dropped once it arrives, unless MEM is frozen.
    assign w_redirect_drop = (r_state == HZ_REDIRECT_PEND) && !i_ic_miss && !i_dc_miss;

    always_comb begin
        w_stall_raw = '0;
        w_flush     = '0;
        case (w_cause)
            HC_DC: begin
                w_stall_raw[STG_IF]  = 1'b1;
                w_stall_raw[STG_DEC] = 1'b1;
                w_stall_raw[STG_EX]  = 1'b1;
                w_stall_raw[STG_MEM] = 1'b1;
                w_flush[STG_WB]      = 1'b1;
            end
            HC_MISPREDICT: begin
                w_flush[STG_DEC] = 1'b1;
                w_flush[STG_EX]  = 1'b1;
            end
            HC_LW: begin
                w_stall_raw[STG_IF]  = 1'b1;
                w_stall_raw[STG_DEC] = 1'b1;
                w_flush[STG_EX]      = 1'b1;
            end
            HC_IC: begin
                w_stall_raw[STG_IF] = 1'b1;
                w_flush[STG_DEC]    = 1'b1;
            end
            default: begin
                w_stall_raw = '0;
            end
        endcase
        if (w_redirect_drop) begin
            w_flush[STG_DEC] = 1'b1;
        end
        if (!rst_n) begin
            w_stall_raw = '0;
            w_flush     = '1;
        end
    end

    assign w_stall = w_stall_raw & ~w_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= HZ_IDLE;
        end else begin
            case (w_cause)
                HC_DC: r_state <= r_state;
                HC_MISPREDICT: begin
                    if (i_ic_miss) begin
                        r_state <= HZ_REDIRECT_PEND;
                    end
                end
                default: begin
                    if (w_redirect_drop) begin
                        r_state <= HZ_IDLE;
                    end
                end
            endcase
        end
    end

    hazard_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stall_any (|w_stall),
        .o_timeout   (o_stall_timeout)
    );

    assign o_if_stall  = w_stall[STG_IF];
    assign o_dec_stall = w_stall[STG_DEC];
    assign o_ex_stall  = w_stall[STG_EX];
    assign o_mem_stall = w_stall[STG_MEM];
    assign o_wb_stall  = w_stall[STG_WB];
    assign o_if_flush  = w_flush[STG_IF];
    assign o_dec_flush = w_flush[STG_DEC];
    assign o_ex_flush  = w_flush[STG_EX];
    assign o_mem_flush = w_flush[STG_MEM];
    assign o_wb_flush  = w_flush[STG_WB];

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] r_cnt_lw;
    logic [CNT_WIDTH-1:0] r_cnt_ic;
    logic [CNT_WIDTH-1:0] r_cnt_dc;
    logic [CNT_WIDTH-1:0] r_cnt_mispredict;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_lw         <= '0;
            r_cnt_ic         <= '0;
            r_cnt_dc         <= '0;
            r_cnt_mispredict <= '0;
        end else begin
            if (w_cause == HC_LW)         r_cnt_lw         <= r_cnt_lw + CNT_WIDTH'(1);
            if (w_cause == HC_IC)         r_cnt_ic         <= r_cnt_ic + CNT_WIDTH'(1);
            if (w_cause == HC_DC)         r_cnt_dc         <= r_cnt_dc + CNT_WIDTH'(1);
            if (w_cause == HC_MISPREDICT) r_cnt_mispredict <= r_cnt_mispredict + CNT_WIDTH'(1);
        end
    end

    assign o_cnt_lw         = r_cnt_lw;
    assign o_cnt_ic         = r_cnt_ic;
    assign o_cnt_dc         = r_cnt_dc;
    assign o_cnt_mispredict = r_cnt_mispredict;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - randomized and directed checks of hazard_controller against a rule-level model
module tb_hazard_controller;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lw = 1'b0, ic = 1'b0, dc = 1'b0, mp = 1'b0;
    logic if_s, dec_s, ex_s, mem_s, wb_s;
    logic if_f, dec_f, ex_f, mem_f, wb_f;
    logic tmo;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] c_lw, c_ic, c_dc, c_mp;
    logic [31:0] m_lw = 0, m_ic = 0, m_dc = 0, m_mp = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    bit pend   = 0;
    int streak = 0;
    bit sticky = 0;

    hazard_controller #(
        .STALL_TIMEOUT (TO)
`ifdef HAZARD_PERF_COUNTERS_EN
        , .CNT_WIDTH   (32)
`endif
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_lw_hazard     (lw),
        .i_ic_miss       (ic),
        .i_dc_miss       (dc),
        .i_ex_mispredict (mp),
        .o_if_stall      (if_s),
        .o_dec_stall     (dec_s),
        .o_ex_stall      (ex_s),
        .o_mem_stall     (mem_s),
        .o_wb_stall      (wb_s),
        .o_if_flush      (if_f),
        .o_dec_flush     (dec_f),
        .o_ex_flush      (ex_f),
        .o_mem_flush     (mem_f),
        .o_wb_flush      (wb_f),
        .o_stall_timeout (tmo)
`ifdef HAZARD_PERF_COUNTERS_EN
        , .o_cnt_lw         (c_lw)
        , .o_cnt_ic         (c_ic)
        , .o_cnt_dc         (c_dc)
        , .o_cnt_mispredict (c_mp)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] dut_outs();
        return {if_s, dec_s, ex_s, mem_s, wb_s, if_f, dec_f, ex_f, mem_f, wb_f};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Outputs are {if,dec,ex,mem,wb} stalls then flushes; rule masks below use the same order.
    always @(negedge clk) begin
        logic [4:0] st, fl;
        int rule;
        st = 5'b0;
        fl = 5'b0;
        rule = 0;
        if (!rst_n) begin
            fl = 5'b11111;
        end else begin
            if (dc)      begin rule = 1; st = 5'b11110; fl = 5'b00001; end
            else if (mp) begin rule = 2; fl = 5'b01100; end
            else if (lw) begin rule = 3; st = 5'b11000; fl = 5'b00100; end
            else if (ic) begin rule = 4; st = 5'b10000; fl = 5'b01000; end
            if (pend && !ic && rule != 1) fl = fl | 5'b01000;
            st = st & ~fl;
        end
        check("model_outs", 32'(dut_outs()), 32'({st, fl}));
        check("model_timeout", 32'(tmo), 32'(sticky));
`ifdef HAZARD_PERF_COUNTERS_EN
        check("model_cnt_lw", c_lw, m_lw);
        check("model_cnt_ic", c_ic, m_ic);
        check("model_cnt_dc", c_dc, m_dc);
        check("model_cnt_mp", c_mp, m_mp);
`endif
        if (!rst_n) begin
            pend = 0; streak = 0; sticky = 0;
`ifdef HAZARD_PERF_COUNTERS_EN
            m_lw = 0; m_ic = 0; m_dc = 0; m_mp = 0;
`endif
        end else begin
            if (rule == 2 && ic) pend = 1;
            else if (rule != 1 && rule != 2 && pend && !ic) pend = 0;
            if (st != 0) streak = (streak + 1 > TO) ? TO : streak + 1;
            else streak = 0;
            if (streak == TO) sticky = 1;
`ifdef HAZARD_PERF_COUNTERS_EN
            if (rule == 1) m_dc++;
            if (rule == 2) m_mp++;
            if (rule == 3) m_lw++;
            if (rule == 4) m_ic++;
`endif
        end
    end

    task automatic step(input logic r, input logic l, input logic i, input logic d, input logic m);
        @(posedge clk);
        #1;
        rst_n = r; lw = l; ic = i; dc = d; mp = m;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // 1: reset then idle
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("reset_outs", 32'(dut_outs()), 32'(10'b00000_11111));
        check("reset_timeout", 32'(tmo), 32'd0);
        step(1, 0, 0, 0, 0);
        check("idle_outs", 32'(dut_outs()), 32'd0);
        // 2: lw beats ic
        step(1, 1, 1, 0, 0);
        check("lw_over_ic", 32'(dut_outs()), 32'(10'b11000_00100));
        // 3: mispredict during I$ miss
        step(1, 0, 1, 0, 1);
        check("mp_ic_c0", 32'(dut_outs()), 32'(10'b00000_01100));
        for (int k = 1; k <= 3; k++) begin
            step(1, 0, 1, 0, 0);
            check("mp_ic_miss", 32'(dut_outs()), 32'(10'b10000_01000));
        end
        step(1, 0, 0, 0, 0);
        check("redirect_drop", 32'(dut_outs()), 32'(10'b00000_01000));
        step(1, 0, 0, 0, 0);
        check("redirect_idle", 32'(dut_outs()), 32'd0);
        // 4: dc miss masks mispredict
        step(1, 0, 0, 1, 1);
        check("dc_over_mp", 32'(dut_outs()), 32'(10'b11110_00001));
        // 5: watchdog
        step(0, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            step(1, 0, 1, 0, 0);
            check("wd_during", 32'(tmo), (k >= 5) ? 32'd1 : 32'd0);
        end
        step(1, 0, 0, 0, 0);
        check("wd_sticky0", 32'(tmo), 32'd1);
        step(1, 0, 0, 0, 0);
        check("wd_sticky1", 32'(tmo), 32'd1);
`ifdef HAZARD_PERF_COUNTERS_EN
        // 6: perf counters
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        check("perf_lw", c_lw, 32'd5);
        check("perf_mp", c_mp, 32'd2);
`endif
        // randomized traffic with occasional reset
        for (int n = 0; n < 4000; n++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 4) == 0));
        end
        step(1, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
